// File: rtl/pic_pkg.sv
// pic_pkg: shared definitions for the 8259A read/acknowledge path.
//   - acknowledge sequencer state encoding
//   - OCW3 read-register select codes
//   - poll-word bit positions and a helper that packs the poll word
package pic_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACK1  = 2'd1,
      ST_WAIT2 = 2'd2,
      ST_ACK2  = 2'd3
   } state_t;

   localparam logic [1:0] RD_IRR = 2'b10;
   localparam logic [1:0] RD_ISR = 2'b11;

   localparam int POLL_I_BIT   = 7;
   localparam int POLL_LVL_MSB = 2;
   localparam int POLL_LVL_LSB = 0;

   function automatic logic [7:0] poll_word(input logic valid, input logic [2:0] lvl);
      logic [7:0] pw;
      pw                           = '0;
      pw[POLL_I_BIT]               = valid;
      pw[POLL_LVL_MSB:POLL_LVL_LSB] = lvl;
      return pw;
   endfunction

endpackage

// File: rtl/inta_responder_strobe_edge.sv
// strobe_edge: samples an active-low strobe into two flops and flags
// falling/rising transitions between the newest sample and the one before.
//   clk      in  system clock
//   rst_n    in  asynchronous active-low reset
//   strobe_n in  active-low strobe, synchronous to clk
//   fall     out newest sample 0, previous sample 1
//   rise     out newest sample 1, previous sample 0
module strobe_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic strobe_n,
   output logic fall,
   output logic rise
);

   logic smp_q;
   logic prv_q;

   // Reset to the inactive level so a strobe held low out of reset is seen as a fall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         smp_q <= 1'b1;
         prv_q <= 1'b1;
      end else begin
         smp_q <= strobe_n;
         prv_q <= smp_q;
      end
   end

   assign fall = prv_q & ~smp_q;
   assign rise = ~prv_q & smp_q;

endmodule

// File: rtl/inta_responder.sv
// inta_responder: CPU-facing read/acknowledge path of the 8259A.
// Sequences the two-pulse INTA cycle (vector on the second pulse) and
// answers RD cycles with IRR, ISR, IMR or the poll word. All outputs registered.
// Optional cascade support when PIC_CASCADE_EN is defined (adds SNGL, ICW3, CAS).
//   CLK/RESET      clock, async active-low reset
//   INTA/RD/A0     CPU strobes (active low) and address bit
//   T7_T3          vector base
//   IRQ_VALID/LEVEL resolver winner
//   IRR/ISR/IMR    register contents for reads
//   READ_SEL/POLL/AEOI  OCW3 read select, poll pending, auto-EOI mode
//   DOUT/DOUT_EN   data bus value and drive enable
//   FREEZE         hold IRR during acknowledge
//   ISR_SET/EOI_AUTO/POLL_DONE  one-cycle pulses to the register block
module inta_responder
   import pic_pkg::*;
#(
   parameter logic [2:0] SPURIOUS_LEVEL = 3'd7
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       INTA,
   input  logic       RD,
   input  logic       A0,
   input  logic [4:0] T7_T3,
   input  logic       IRQ_VALID,
   input  logic [2:0] IRQ_LEVEL,
   input  logic [7:0] IRR,
   input  logic [7:0] ISR,
   input  logic [7:0] IMR,
   input  logic [1:0] READ_SEL,
   input  logic       POLL,
   input  logic       AEOI,
`ifdef PIC_CASCADE_EN
   input  logic       SNGL,
   input  logic [7:0] ICW3,
   output logic [2:0] CAS,
`endif
   output logic [7:0] DOUT,
   output logic       DOUT_EN,
   output logic       FREEZE,
   output logic [7:0] ISR_SET,
   output logic       EOI_AUTO,
   output logic       POLL_DONE
);

   logic inta_fall, inta_rise, rd_fall, rd_rise;

   strobe_edge u_inta_edge (.clk(CLK), .rst_n(RESET), .strobe_n(INTA), .fall(inta_fall), .rise(inta_rise));
   strobe_edge u_rd_edge   (.clk(CLK), .rst_n(RESET), .strobe_n(RD),   .fall(rd_fall),   .rise(rd_rise));

   state_t     state_q, state_d;
   logic [2:0] lvl_q, lvl_d;
   logic       spur_q, spur_d;
   logic       sel_isr_q, sel_isr_d;
   logic       rd_act_q, rd_act_d;
   logic       poll_hold_q, poll_hold_d;
   logic [7:0] dout_d;
   logic       dout_en_d, freeze_d, eoi_d, pdone_d;
   logic [7:0] isr_set_d;
`ifdef PIC_CASCADE_EN
   logic [2:0] cas_d;
   logic       slave_q, slave_d;
`endif

   logic [2:0] ack_lvl;
   logic [7:0] read_word;

   assign ack_lvl   = IRQ_VALID ? IRQ_LEVEL : SPURIOUS_LEVEL;
   assign read_word = A0 ? IMR : (sel_isr_q ? ISR : IRR);

   // State and output registers
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q     <= ST_IDLE;
         lvl_q       <= '0;
         spur_q      <= 1'b0;
         sel_isr_q   <= 1'b0;
         rd_act_q    <= 1'b0;
         poll_hold_q <= 1'b0;
         DOUT        <= '0;
         DOUT_EN     <= 1'b0;
         FREEZE      <= 1'b0;
         ISR_SET     <= '0;
         EOI_AUTO    <= 1'b0;
         POLL_DONE   <= 1'b0;
`ifdef PIC_CASCADE_EN
         CAS         <= '0;
         slave_q     <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         lvl_q       <= lvl_d;
         spur_q      <= spur_d;
         sel_isr_q   <= sel_isr_d;
         rd_act_q    <= rd_act_d;
         poll_hold_q <= poll_hold_d;
         DOUT        <= dout_d;
         DOUT_EN     <= dout_en_d;
         FREEZE      <= freeze_d;
         ISR_SET     <= isr_set_d;
         EOI_AUTO    <= eoi_d;
         POLL_DONE   <= pdone_d;
`ifdef PIC_CASCADE_EN
         CAS         <= cas_d;
         slave_q     <= slave_d;
`endif
      end
   end

   // Next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (inta_fall) state_d = ST_ACK1;
         ST_ACK1:  if (inta_rise) state_d = ST_WAIT2;  // a repeated fall here is a glitch
         ST_WAIT2: if (inta_fall) state_d = ST_ACK2;
         ST_ACK2:  if (inta_rise) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Output / datapath next values
   always_comb begin
      lvl_d       = lvl_q;
      spur_d      = spur_q;
      rd_act_d    = rd_act_q;
      poll_hold_d = poll_hold_q;
      dout_d      = DOUT;
      dout_en_d   = DOUT_EN;
      freeze_d    = FREEZE;
      isr_set_d   = '0;
      eoi_d       = 1'b0;
      pdone_d     = 1'b0;
      sel_isr_d   = sel_isr_q;
`ifdef PIC_CASCADE_EN
      cas_d       = CAS;
      slave_d     = slave_q;
`endif
      // Only RR=1 updates the selection; RR=0 keeps the last one.
      if (READ_SEL[1]) sel_isr_d = (READ_SEL == RD_ISR);

      unique case (state_q)
         ST_IDLE: begin
            if (inta_fall) begin
               // Acknowledge wins over a simultaneous or active read.
               lvl_d       = ack_lvl;
               spur_d      = ~IRQ_VALID;
               if (IRQ_VALID) isr_set_d = 8'd1 << IRQ_LEVEL;
               freeze_d    = 1'b1;
               dout_en_d   = 1'b0;
               rd_act_d    = 1'b0;
               poll_hold_d = 1'b0;
`ifdef PIC_CASCADE_EN
               slave_d     = ~SNGL & ICW3[ack_lvl];
               cas_d       = (~SNGL & ICW3[ack_lvl]) ? ack_lvl : 3'd0;
`endif
            end else if (rd_fall) begin
               rd_act_d  = 1'b1;
               dout_en_d = 1'b1;
               if (!A0 && POLL) begin
                  // Poll word is frozen for the whole read.
                  dout_d      = poll_word(IRQ_VALID, IRQ_LEVEL);
                  poll_hold_d = 1'b1;
                  pdone_d     = 1'b1;
                  if (IRQ_VALID) isr_set_d = 8'd1 << IRQ_LEVEL;
               end else begin
                  dout_d = read_word;
               end
            end else if (rd_rise) begin
               rd_act_d    = 1'b0;
               poll_hold_d = 1'b0;
               dout_en_d   = 1'b0;
            end else if (rd_act_q && !poll_hold_q) begin
               dout_d = read_word;
            end
         end
         ST_WAIT2: begin
            if (inta_fall) begin
               dout_d = {T7_T3, lvl_q};
`ifdef PIC_CASCADE_EN
               dout_en_d = ~slave_q;  // slave drives the vector
`else
               dout_en_d = 1'b1;
`endif
            end
         end
         ST_ACK2: begin
            if (inta_rise) begin
               dout_en_d = 1'b0;
               freeze_d  = 1'b0;
               eoi_d     = AEOI & ~spur_q;
`ifdef PIC_CASCADE_EN
               cas_d     = '0;
               slave_d   = 1'b0;
`endif
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_inta_responder.sv
module tb_inta_responder;

   logic       CLK = 1'b0;
   logic       RESET, INTA, RD, A0, IRQ_VALID, POLL, AEOI;
   logic [4:0] T7_T3;
   logic [2:0] IRQ_LEVEL;
   logic [7:0] IRR, ISR, IMR;
   logic [1:0] READ_SEL;
   logic [7:0] DOUT, ISR_SET;
   logic       DOUT_EN, FREEZE, EOI_AUTO, POLL_DONE;
`ifdef PIC_CASCADE_EN
   logic       SNGL = 1'b1;
   logic [7:0] ICW3 = 8'h00;
   logic [2:0] CAS;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   inta_responder dut (
      .CLK(CLK), .RESET(RESET), .INTA(INTA), .RD(RD), .A0(A0), .T7_T3(T7_T3),
      .IRQ_VALID(IRQ_VALID), .IRQ_LEVEL(IRQ_LEVEL), .IRR(IRR), .ISR(ISR), .IMR(IMR),
      .READ_SEL(READ_SEL), .POLL(POLL), .AEOI(AEOI),
`ifdef PIC_CASCADE_EN
      .SNGL(SNGL), .ICW3(ICW3), .CAS(CAS),
`endif
      .DOUT(DOUT), .DOUT_EN(DOUT_EN), .FREEZE(FREEZE), .ISR_SET(ISR_SET),
      .EOI_AUTO(EOI_AUTO), .POLL_DONE(POLL_DONE));

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // phase: 0 idle, 1 in first pulse, 2 between pulses, 3 in second pulse
   int         m_phase;
   logic [1:0] m_ia, m_rd;    // [0] newest sample, [1] previous
   logic [2:0] m_lvl;
   logic       m_spur, m_sel_isr, m_reading, m_hold;
   logic [7:0] e_dout, e_isr;
   logic       e_en, e_frz, e_eoi, e_pd;

   always @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         m_phase = 0; m_ia = 2'b11; m_rd = 2'b11; m_lvl = 0; m_spur = 0;
         m_sel_isr = 0; m_reading = 0; m_hold = 0;
         e_dout = 0; e_isr = 0; e_en = 0; e_frz = 0; e_eoi = 0; e_pd = 0;
      end else begin
         logic ifall, irise, rfall, rrise;
         logic [7:0] rd_val;
         ifall  = m_ia[1] && !m_ia[0];
         irise  = !m_ia[1] && m_ia[0];
         rfall  = m_rd[1] && !m_rd[0];
         rrise  = !m_rd[1] && m_rd[0];
         rd_val = A0 ? IMR : (m_sel_isr ? ISR : IRR);
         e_isr = 0; e_eoi = 0; e_pd = 0;
         if (m_phase == 0) begin
            if (ifall) begin
               m_spur = !IRQ_VALID;
               m_lvl  = IRQ_VALID ? IRQ_LEVEL : 3'd7;
               if (IRQ_VALID) e_isr = 8'd1 << IRQ_LEVEL;
               e_frz = 1; e_en = 0; m_reading = 0; m_hold = 0; m_phase = 1;
            end else if (rfall) begin
               m_reading = 1; e_en = 1;
               if (!A0 && POLL) begin
                  e_dout = IRQ_VALID * 128 + IRQ_LEVEL;
                  m_hold = 1; e_pd = 1;
                  if (IRQ_VALID) e_isr = 8'd1 << IRQ_LEVEL;
               end else e_dout = rd_val;
            end else if (rrise) begin
               m_reading = 0; m_hold = 0; e_en = 0;
            end else if (m_reading && !m_hold) e_dout = rd_val;
         end else if (m_phase == 1) begin
            if (irise) m_phase = 2;
         end else if (m_phase == 2) begin
            if (ifall) begin e_dout = T7_T3 * 8 + m_lvl; e_en = 1; m_phase = 3; end
         end else begin
            if (irise) begin
               e_en = 0; e_frz = 0; e_eoi = AEOI && !m_spur; m_phase = 0;
            end
         end
         if (READ_SEL[1]) m_sel_isr = READ_SEL[0];
         m_ia = {m_ia[0], INTA};
         m_rd = {m_rd[0], RD};
      end
   end

   // ---------------- per-cycle compare + trackers ----------------
   logic [7:0] seen_isr;
   int         eoi_cnt, pd_cnt;

   always @(negedge CLK) begin
      chk("dout_en", DOUT_EN, e_en);
      chk("freeze", FREEZE, e_frz);
      chk("isr_set", ISR_SET, e_isr);
      chk("eoi_auto", EOI_AUTO, e_eoi);
      chk("poll_done", POLL_DONE, e_pd);
      if (e_en) chk("dout", DOUT, e_dout);
`ifdef PIC_CASCADE_EN
      chk("cas", CAS, 0);
`endif
      seen_isr = seen_isr | ISR_SET;
      eoi_cnt  = eoi_cnt + int'(EOI_AUTO);
      pd_cnt   = pd_cnt + int'(POLL_DONE);
   end

   // ---------------- stimulus ----------------
   logic [7:0] smp_dout;
   logic       smp_en, smp_frz;

   task automatic clr_trk();
      seen_isr = 0; eoi_cnt = 0; pd_cnt = 0;
   endtask

   // One INTA pulse; bus state is sampled late in the low phase.
   task automatic inta_pulse();
      @(negedge CLK); INTA = 0;
      repeat (3) @(negedge CLK);
      smp_dout = DOUT; smp_en = DOUT_EN; smp_frz = FREEZE;
      INTA = 1;
      repeat (3) @(negedge CLK);
   endtask

   task automatic rd_cycle(input logic a0);
      @(negedge CLK); RD = 0; A0 = a0;
      repeat (3) @(negedge CLK);
      smp_dout = DOUT; smp_en = DOUT_EN;
      RD = 1;
      repeat (3) @(negedge CLK);
   endtask

   initial begin
      seen_isr = 0; eoi_cnt = 0; pd_cnt = 0;
      RESET = 1; INTA = 1; RD = 1; A0 = 0; IRQ_VALID = 0; POLL = 0; AEOI = 0;
      T7_T3 = 5'h11; IRQ_LEVEL = 0; IRR = 8'h5A; ISR = 8'h00; IMR = 8'h00; READ_SEL = 2'b00;
      #1 RESET = 0;
      repeat (2) @(negedge CLK);
      chk("rst_dout", DOUT, 8'h00);
      chk("rst_en", DOUT_EN, 0);
      chk("rst_freeze", FREEZE, 0);
      @(negedge CLK); RESET = 1;
      repeat (2) @(negedge CLK);

      // valid level 3, AEOI
      IRQ_VALID = 1; IRQ_LEVEL = 3; AEOI = 1; clr_trk();
      inta_pulse();
      chk("p1_isr_set", seen_isr, 8'h08);
      chk("p1_bus_float", smp_en, 0);
      chk("p1_freeze", smp_frz, 1);
      IRQ_LEVEL = 5;  // resolver moves on; vector must keep latched level
      inta_pulse();
      chk("p2_vector", smp_dout, 8'h8B);
      chk("p2_en", smp_en, 1);
      chk("p2_freeze", smp_frz, 1);
      chk("eoi_once", eoi_cnt, 1);
      chk("freeze_released", FREEZE, 0);

      // spurious
      IRQ_VALID = 0; clr_trk();
      inta_pulse(); inta_pulse();
      chk("spur_vector", smp_dout, 8'h8F);
      chk("spur_isr_set", seen_isr, 8'h00);
      chk("spur_eoi", eoi_cnt, 0);
      AEOI = 0;

      // register reads
      ISR = 8'h24; IMR = 8'hF0;
      @(negedge CLK); READ_SEL = 2'b11;
      @(negedge CLK); READ_SEL = 2'b00;
      rd_cycle(0);
      chk("read_isr", smp_dout, 8'h24);
      chk("read_en", smp_en, 1);
      chk("read_released", DOUT_EN, 0);
      rd_cycle(1);
      chk("read_imr", smp_dout, 8'hF0);
      // live tracking inside one read
      @(negedge CLK); RD = 0; A0 = 0;
      repeat (3) @(negedge CLK);
      chk("read_isr_hold_sel", DOUT, 8'h24);
      ISR = 8'h25;
      repeat (2) @(negedge CLK);
      chk("read_isr_live", DOUT, 8'h25);
      RD = 1; repeat (3) @(negedge CLK);
      @(negedge CLK); READ_SEL = 2'b10;
      rd_cycle(0);
      chk("read_irr", smp_dout, 8'h5A);

      // poll
      POLL = 1; IRQ_VALID = 1; IRQ_LEVEL = 6; clr_trk();
      @(negedge CLK); RD = 0; A0 = 0;
      repeat (3) @(negedge CLK);
      IRQ_LEVEL = 1;  // captured word must not follow
      repeat (2) @(negedge CLK);
      chk("poll_word", DOUT, 8'h86);
      RD = 1; repeat (3) @(negedge CLK);
      chk("poll_isr_set", seen_isr, 8'h40);
      chk("poll_done_once", pd_cnt, 1);
      IRQ_VALID = 0; IRQ_LEVEL = 0; clr_trk();
      rd_cycle(0);
      chk("poll_empty", smp_dout, 8'h00);
      chk("poll_empty_isr", seen_isr, 8'h00);
      chk("poll_empty_done", pd_cnt, 1);
      POLL = 0;

      // reset while between pulses
      IRQ_VALID = 1; IRQ_LEVEL = 2;
      inta_pulse();
      @(negedge CLK); #2 RESET = 0; #1;
      chk("midrst_freeze", FREEZE, 0);
      chk("midrst_en", DOUT_EN, 0);
      repeat (2) @(negedge CLK); RESET = 1;
      repeat (2) @(negedge CLK);
      clr_trk();
      inta_pulse(); inta_pulse();
      chk("postrst_isr", seen_isr, 8'h04);
      chk("postrst_vector", smp_dout, 8'h8A);

      // INTA and RD falling together: acknowledge only
      IRQ_LEVEL = 1; clr_trk();
      @(negedge CLK); INTA = 0; RD = 0; A0 = 1;
      repeat (3) @(negedge CLK);
      chk("tie_no_read", DOUT_EN, 0);
      INTA = 1; repeat (3) @(negedge CLK);
      RD = 1; repeat (3) @(negedge CLK);
      inta_pulse();
      chk("tie_vector", smp_dout, 8'h89);
      chk("tie_isr", seen_isr, 8'h02);

      // INTA during an active read
      @(negedge CLK); RD = 0; A0 = 1;
      repeat (3) @(negedge CLK);
      chk("pre_abort_en", DOUT_EN, 1);
      INTA = 0; repeat (3) @(negedge CLK);
      chk("abort_en", DOUT_EN, 0);
      chk("abort_freeze", FREEZE, 1);
      INTA = 1; repeat (3) @(negedge CLK);
      RD = 1; repeat (2) @(negedge CLK);
      inta_pulse();
      chk("abort_vector", smp_dout, 8'h89);
      repeat (3) @(negedge CLK);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
